// File: rtl/pla_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pla_delay_ctrl
// Description : Run-time controller for the C64 PLA output-delay selects.
//               Chooses between solder-bridge straps and a config byte, and
//               sequences every select change so it is applied only after the
//               delay-line tap monitors have been quiet for STABLE_CYCLES
//               (or after TIMEOUT_CYCLES, as a forced apply).
// Ports       : clk_i/rst_i       - clock, async active-high reset
//               strap_speed_i     - async strap, general speed select
//               strap_cas_i[1:0]  - async strap, CAS tap select
//               mon_i[5:0]        - async tap monitors (quiet = all equal)
//               cfg_valid_i/cfg_data_i[7:0]/cfg_ready_o - config handshake
//               speed_sel_o, cas_sel_o[1:0] - selects to the PLA wrapper
//               busy_o, override_o, timeout_o (sticky) - status
// Revision    : 1.0 - initial release
// ============================================================================
module pla_delay_ctrl #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       strap_speed_i,
    input  logic [1:0] strap_cas_i,
    input  logic [5:0] mon_i,
    input  logic       cfg_valid_i,
    input  logic [7:0] cfg_data_i,
    output logic       cfg_ready_o,
    output logic       speed_sel_o,
    output logic [1:0] cas_sel_o,
    output logic       busy_o,
    output logic       override_o,
    output logic       timeout_o
);

    localparam int c_cnt_max = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_sat = c_cnt_w'(c_cnt_max);
    localparam logic [c_cnt_w-1:0] c_stable  = c_cnt_w'(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_STABLE = 2'd1,
        APPLY       = 2'd2
    } state_t;

    // Two-flop synchronizers; packed as {speed, cas} to match the target layout
    logic [2:0] strap_meta_q, strap_sync_q;
    logic [5:0] mon_meta_q, mon_sync_q;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;          // {speed_sel, cas_sel}
    logic [2:0]         target_q, target_d;
    logic [c_cnt_w-1:0] stable_cnt_q, stable_cnt_d;
    logic [c_cnt_w-1:0] timeout_cnt_q, timeout_cnt_d;
    logic               override_q, override_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;

    logic               quiet;
    logic               req_vld;
    logic [2:0]         req_tgt;
    logic [c_cnt_w-1:0] stable_nxt;
    logic [c_cnt_w-1:0] timeout_nxt;

    // Low nibble of the config byte carries no function
    logic cfg_low_unused;
    assign cfg_low_unused = ^cfg_data_i[3:0];

    assign quiet = (mon_sync_q == 6'h00) || (mon_sync_q == 6'h3F);

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        target_d      = target_q;
        stable_cnt_d  = stable_cnt_q;
        timeout_cnt_d = timeout_cnt_q;
        override_d    = override_q;
        timeout_d     = timeout_q;
        req_vld       = 1'b0;
        req_tgt       = strap_sync_q;
        // Saturating increments; the compare below looks at the next count
        // so APPLY starts the cycle after the threshold is reached.
        stable_nxt    = (stable_cnt_q == c_cnt_sat) ? stable_cnt_q : stable_cnt_q + c_one;
        timeout_nxt   = (timeout_cnt_q == c_cnt_sat) ? timeout_cnt_q : timeout_cnt_q + c_one;

        case (state_q)
            IDLE: begin
                // Config handshake takes priority over a strap difference;
                // the strap check reruns on the next IDLE cycle.
                if (cfg_valid_i) begin
                    override_d = cfg_data_i[7];
                    req_vld    = 1'b1;
                    req_tgt    = cfg_data_i[7] ? cfg_data_i[6:4] : strap_sync_q;
                end else if (!override_q && (strap_sync_q != sel_q)) begin
                    req_vld = 1'b1;
                    req_tgt = strap_sync_q;
                end
                if (req_vld && (req_tgt != sel_q)) begin
                    target_d      = req_tgt;
                    stable_cnt_d  = '0;
                    timeout_cnt_d = '0;
                    state_d       = WAIT_STABLE;
                end
            end
            WAIT_STABLE: begin
                stable_cnt_d  = quiet ? stable_nxt : '0;
                timeout_cnt_d = timeout_nxt;
                if (quiet && (stable_nxt == c_stable)) begin
                    state_d = APPLY;
                end else if (timeout_nxt == c_timeout) begin
                    timeout_d = 1'b1;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                sel_d   = target_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            strap_meta_q  <= '0;
            strap_sync_q  <= '0;
            mon_meta_q    <= '0;
            mon_sync_q    <= '0;
            state_q       <= IDLE;
            sel_q         <= '0;
            target_q      <= '0;
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            override_q    <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            strap_meta_q  <= {strap_speed_i, strap_cas_i};
            strap_sync_q  <= strap_meta_q;
            mon_meta_q    <= mon_i;
            mon_sync_q    <= mon_meta_q;
            state_q       <= state_d;
            sel_q         <= sel_d;
            target_q      <= target_d;
            stable_cnt_q  <= stable_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            override_q    <= override_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

    assign speed_sel_o = sel_q[2];
    assign cas_sel_o   = sel_q[1:0];
    assign busy_o      = busy_q;
    assign cfg_ready_o = ~busy_q;
    assign override_o  = override_q;
    assign timeout_o   = timeout_q;

endmodule
`default_nettype wire
